// File: rtl/mem_writer.sv
// mem_writer: streams result lines into a host buffer over CCI-P channel 1.
//
// A job is launched by a one-cycle start while the buffer address is
// programmed. Each accepted result line becomes exactly one channel-1 write
// request on the following cycle, tagged with its line index. The number of
// un-acknowledged writes is capped at MAX_OUTSTANDING. The job finishes once
// every line has been issued and acknowledged, which raises a one-cycle done.
//
// Ports
//   clk            : clock, all logic on the rising edge
//   rst            : asynchronous active-high reset
//   buffer_addr    : host byte address of the result buffer (0 = unprogrammed)
//   start          : one-cycle job request, honoured only in IDLE
//   num_lines      : number of 64-byte lines in the job
//   wr_data_valid  : result line on wr_data is valid
//   wr_data        : result line payload
//   wr_data_ready  : line accepted this cycle (combinational)
//   c1_almost_full : CCI-P channel-1 back-pressure
//   c1_tx_valid    : channel-1 write request valid
//   c1_tx_addr     : cache-line address of the write
//   c1_tx_data     : write payload
//   c1_tx_mdata    : request tag (line index)
//   c1_rx_valid    : channel-1 write response, one line acknowledged
//   busy           : high whenever the FSM is outside IDLE
//   done           : one-cycle job-complete pulse
//   lines_written  : acknowledged lines in the current or last job
module mem_writer #(
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [63:0]  buffer_addr,
    input  logic         start,
    input  logic [15:0]  num_lines,
    input  logic         wr_data_valid,
    input  logic [511:0] wr_data,
    output logic         wr_data_ready,
    input  logic         c1_almost_full,
    output logic         c1_tx_valid,
    output logic [41:0]  c1_tx_addr,
    output logic [511:0] c1_tx_data,
    output logic [15:0]  c1_tx_mdata,
    input  logic         c1_rx_valid,
    output logic         busy,
    output logic         done,
    output logic [15:0]  lines_written
);

    localparam int unsigned LINE_W = 16;
    localparam int unsigned ADDR_W = 42;
    localparam int unsigned DATA_W = 512;
    // One extra bit so the counter can hold MAX_OUTSTANDING itself.
    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base;
    logic [LINE_W-1:0]   total;
    logic [LINE_W-1:0]   issued;
    logic [OUT_W-1:0]    outstanding;
    logic                accept;
    logic                rsp_take;

    // Acceptance gate: back-pressure, credit limit and remaining lines.
    assign wr_data_ready = (state == WRITE)
                        && !c1_almost_full
                        && (outstanding < OUT_W'(MAX_OUTSTANDING))
                        && (issued < total);

    assign accept = wr_data_valid && wr_data_ready;

    // A response with nothing outstanding is stale (e.g. from an aborted job).
    assign rsp_take = c1_rx_valid && (outstanding != '0);

    // Job FSM, request register and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            base          <= '0;
            total         <= '0;
            issued        <= '0;
            outstanding   <= '0;
            lines_written <= '0;
            c1_tx_valid   <= 1'b0;
            c1_tx_addr    <= '0;
            c1_tx_data    <= '0;
            c1_tx_mdata   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done        <= 1'b0;
            c1_tx_valid <= accept;

            // Register the accepted line as next cycle's write request.
            if (accept) begin
                c1_tx_addr  <= base + ADDR_W'(issued);
                c1_tx_data  <= DATA_W'(wr_data);
                c1_tx_mdata <= issued;
                issued      <= issued + LINE_W'(1);
            end

            // A simultaneous accept and response cancel out.
            case ({accept, rsp_take})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (rsp_take) begin
                lines_written <= lines_written + LINE_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start && (buffer_addr != '0)) begin
                        base          <= buffer_addr[47:6];
                        total         <= num_lines;
                        issued        <= '0;
                        outstanding   <= '0;
                        lines_written <= '0;
                        busy          <= 1'b1;
                        state         <= (num_lines == '0) ? DONE : WRITE;
                    end
                end
                WRITE: begin
                    if (issued == total) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((outstanding == '0) && !c1_tx_valid) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_writer.sv
// Scoreboard bench for mem_writer: expected requests are queued when a job is
// launched, a monitor pops and compares every channel-1 request, and a
// responder acknowledges requests after a fixed delay or on demand.
module tb_mem_writer;

    localparam int unsigned MAXO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  buffer_addr;
    logic         start;
    logic [15:0]  num_lines;
    logic         wr_data_valid;
    logic [511:0] wr_data;
    logic         wr_data_ready;
    logic         c1_almost_full;
    logic         c1_tx_valid;
    logic [41:0]  c1_tx_addr;
    logic [511:0] c1_tx_data;
    logic [15:0]  c1_tx_mdata;
    logic         c1_rx_valid;
    logic         busy;
    logic         done;
    logic [15:0]  lines_written;

    always #5 clk = ~clk;

    mem_writer #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk            (clk),
        .rst            (rst),
        .buffer_addr    (buffer_addr),
        .start          (start),
        .num_lines      (num_lines),
        .wr_data_valid  (wr_data_valid),
        .wr_data        (wr_data),
        .wr_data_ready  (wr_data_ready),
        .c1_almost_full (c1_almost_full),
        .c1_tx_valid    (c1_tx_valid),
        .c1_tx_addr     (c1_tx_addr),
        .c1_tx_data     (c1_tx_data),
        .c1_tx_mdata    (c1_tx_mdata),
        .c1_rx_valid    (c1_rx_valid),
        .busy           (busy),
        .done           (done),
        .lines_written  (lines_written)
    );

    typedef struct packed {
        logic [41:0]  addr;
        logic [15:0]  mdata;
        logic [511:0] data;
    } req_t;

    req_t        exp_q[$];
    int unsigned rsp_due[$];
    int unsigned n_vec    = 0;
    int unsigned n_err    = 0;
    int unsigned cyc      = 0;
    int unsigned req_cnt  = 0;
    int unsigned done_cnt = 0;
    int unsigned hs_cnt   = 0;
    int unsigned hs_in_af = 0;
    int unsigned rel_req  = 0;
    int unsigned rel_done = 0;
    logic        hs_last  = 1'b0;
    logic        dv_en    = 1'b0;
    logic        af_ctl   = 1'b0;
    logic        rsp_hold = 1'b0;
    logic [7:0]  job_id   = 8'd0;

    function automatic logic [511:0] pat(input logic [7:0] j, input int unsigned i);
        logic [31:0] w;
        w = {j, 8'(i), ~j, 8'(i) ^ 8'h5A};
        return {16{w}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_req(input logic [41:0] a, input logic [15:0] m, input logic [511:0] d);
        req_t e;
        e.addr  = a;
        e.mdata = m;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    // Main-process actions happen 2 time units after a falling edge.
    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic new_job(input logic [7:0] jid);
        job_id  = jid;
        hs_cnt  = 0;
        hs_last = 1'b0;
    endtask

    task automatic start_job(input logic [63:0] a, input logic [15:0] n);
        buffer_addr = a;
        num_lines   = n;
        start       = 1'b1;
        step(1);
        start       = 1'b0;
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        int unsigned d0;
        int unsigned k;
        d0 = done_cnt;
        k  = 0;
        while ((done_cnt == d0) && (k < budget)) begin
            step(1);
            k++;
        end
        if (done_cnt == d0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done in %0d cycles, expected done", name, budget);
        end
        step(3);
        check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    endtask

    // Monitor: compares each request against the scoreboard, schedules its response.
    task automatic monitor();
        req_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (done) done_cnt++;
            if (c1_tx_valid) begin
                req_cnt++;
                rsp_due.push_back(cyc + 5);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_req: got addr 0x%0h mdata %0d, expected no request",
                             c1_tx_addr, c1_tx_mdata);
                end else begin
                    e = exp_q.pop_front();
                    check("req_addr", 64'(c1_tx_addr), 64'(e.addr));
                    check("req_mdata", 64'(c1_tx_mdata), 64'(e.mdata));
                    n_vec++;
                    if (c1_tx_data !== e.data) begin
                        n_err++;
                        $display("FAIL req_data: got 0x%0h, expected 0x%0h", c1_tx_data, e.data);
                    end
                end
            end
        end
    endtask

    // Driver: line data, back-pressure and responses, all changed on falling edges.
    task automatic driver();
        forever begin
            @(negedge clk);
            if (hs_last) hs_cnt++;
            wr_data_valid  = dv_en;
            c1_almost_full = af_ctl;
            wr_data        = pat(job_id, hs_cnt);
            c1_rx_valid    = 1'b0;
            if (rsp_due.size() != 0) begin
                if (rsp_hold) begin
                    if (rel_req != rel_done) begin
                        c1_rx_valid = 1'b1;
                        void'(rsp_due.pop_front());
                        rel_done++;
                    end
                end else if (rsp_due[0] <= cyc) begin
                    c1_rx_valid = 1'b1;
                    void'(rsp_due.pop_front());
                end
            end
            #4;
            hs_last = wr_data_valid && wr_data_ready;
            if (hs_last && c1_almost_full) hs_in_af++;
        end
    endtask

    initial begin
        int unsigned r0;
        int unsigned r1;
        int unsigned d0;
        int unsigned k;

        rst            = 1'b1;
        buffer_addr    = '0;
        start          = 1'b0;
        num_lines      = '0;
        wr_data_valid  = 1'b0;
        wr_data        = '0;
        c1_almost_full = 1'b0;
        c1_rx_valid    = 1'b0;

        fork
            monitor();
            driver();
        join_none

        // Reset state
        step(3);
        check("rst_tx_valid", 64'(c1_tx_valid), 64'd0);
        check("rst_ready", 64'(wr_data_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_lines", 64'(lines_written), 64'd0);
        check("rst_addr", 64'(c1_tx_addr), 64'd0);
        check("rst_mdata", 64'(c1_tx_mdata), 64'd0);
        rst = 1'b0;
        step(2);

        // Basic 4-line job, responses 5 cycles after each request
        dv_en    = 1'b1;
        rsp_hold = 1'b0;
        af_ctl   = 1'b0;
        new_job(8'd1);
        for (int unsigned i = 0; i < 4; i++) expect_req(42'h40 + 42'(i), 16'(i), pat(8'd1, i));
        r0 = req_cnt;
        start_job(64'h1000, 16'd4);
        wait_done("basic", 200);
        check("basic_lines", 64'(lines_written), 64'd4);
        check("basic_reqs", 64'(req_cnt - r0), 64'd4);
        check("basic_busy", 64'(busy), 64'd0);
        check("basic_sb_empty", 64'(exp_q.size()), 64'd0);

        // Credit limit: responses withheld, then released one at a time
        rsp_hold = 1'b1;
        new_job(8'd2);
        for (int unsigned i = 0; i < 20; i++) expect_req(42'h80 + 42'(i), 16'(i), pat(8'd2, i));
        r0 = req_cnt;
        start_job(64'h2000, 16'd20);
        step(40);
        check("cap_reqs", 64'(req_cnt - r0), 64'd16);
        check("cap_ready", 64'(wr_data_ready), 64'd0);
        check("cap_busy", 64'(busy), 64'd1);
        rel_req++;
        step(10);
        check("cap_release_reqs", 64'(req_cnt - r0), 64'd17);
        check("cap_release_lines", 64'(lines_written), 64'd1);
        rsp_hold = 1'b0;
        wait_done("cap", 400);
        check("cap_lines", 64'(lines_written), 64'd20);
        check("cap_sb_empty", 64'(exp_q.size()), 64'd0);

        // Almost-full window mid-job
        new_job(8'd3);
        for (int unsigned i = 0; i < 12; i++) expect_req(42'h1000 + 42'(i), 16'(i), pat(8'd3, i));
        r0 = req_cnt;
        start_job(64'h40000, 16'd12);
        step(4);
        af_ctl   = 1'b1;
        hs_in_af = 0;
        r1       = req_cnt;
        step(10);
        check("af_hs_in_window", 64'(hs_in_af), 64'd0);
        check("af_reqs_in_window", 64'(req_cnt - r1), 64'd1);
        af_ctl = 1'b0;
        wait_done("af", 300);
        check("af_lines", 64'(lines_written), 64'd12);
        check("af_reqs", 64'(req_cnt - r0), 64'd12);
        check("af_sb_empty", 64'(exp_q.size()), 64'd0);

        // Start with an unprogrammed buffer address is ignored
        d0 = done_cnt;
        start_job(64'h0, 16'd5);
        for (int unsigned i = 0; i < 5; i++) begin
            check("noaddr_busy", 64'(busy), 64'd0);
            step(1);
        end
        check("noaddr_no_done", 64'(done_cnt - d0), 64'd0);
        check("noaddr_lines_held", 64'(lines_written), 64'd12);

        // Zero-length job: done two cycles after start, no request
        new_job(8'd4);
        r0 = req_cnt;
        d0 = done_cnt;
        start_job(64'h5000, 16'd0);
        check("zero_busy", 64'(busy), 64'd1);
        check("zero_done_early", 64'(done), 64'd0);
        step(1);
        check("zero_done_pulse", 64'(done), 64'd1);
        step(3);
        check("zero_no_req", 64'(req_cnt - r0), 64'd0);
        check("zero_done_count", 64'(done_cnt - d0), 64'd1);
        check("zero_lines", 64'(lines_written), 64'd0);
        check("zero_busy_after", 64'(busy), 64'd0);

        // Address wrap at 2^42 lines
        new_job(8'd5);
        expect_req(42'h3FF_FFFF_FFFF, 16'd0, pat(8'd5, 0));
        expect_req(42'h000_0000_0000, 16'd1, pat(8'd5, 1));
        start_job(64'h03FF_FFFF_FFFF_FFC0, 16'd2);
        wait_done("wrap", 200);
        check("wrap_lines", 64'(lines_written), 64'd2);
        check("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset after three of eight lines issued
        new_job(8'd6);
        rsp_hold = 1'b1;
        for (int unsigned i = 0; i < 3; i++) expect_req(42'h200 + 42'(i), 16'(i), pat(8'd6, i));
        r0 = req_cnt;
        start_job(64'h8000, 16'd8);
        k = 0;
        while (((req_cnt - r0) < 3) && (k < 50)) begin
            step(1);
            k++;
        end
        check("abort_pre_reqs", 64'(req_cnt - r0), 64'd3);
        rst = 1'b1;
        #1;
        check("abort_tx_valid", 64'(c1_tx_valid), 64'd0);
        check("abort_ready", 64'(wr_data_ready), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_lines", 64'(lines_written), 64'd0);
        check("abort_addr", 64'(c1_tx_addr), 64'd0);
        check("abort_mdata", 64'(c1_tx_mdata), 64'd0);
        check("abort_data_nonzero", 64'(|c1_tx_data), 64'd0);
        step(2);
        rst = 1'b0;
        step(1);
        rsp_hold = 1'b0;
        step(10);
        check("abort_late_lines", 64'(lines_written), 64'd0);
        check("abort_late_busy", 64'(busy), 64'd0);
        check("abort_no_more_reqs", 64'(req_cnt - r0), 64'd3);
        check("abort_sb_empty", 64'(exp_q.size()), 64'd0);
        check("abort_rsp_drained", 64'(rsp_due.size()), 64'd0);

        // Fresh job after the abort
        new_job(8'd7);
        for (int unsigned i = 0; i < 5; i++) expect_req(42'h40 + 42'(i), 16'(i), pat(8'd7, i));
        r0 = req_cnt;
        start_job(64'h1000, 16'd5);
        wait_done("after_abort", 200);
        check("after_abort_lines", 64'(lines_written), 64'd5);
        check("after_abort_reqs", 64'(req_cnt - r0), 64'd5);
        check("after_abort_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_writer.md
MEM_WRITER -- requirements
Module: mem_writer

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 16, giving the maximum number of un-acknowledged CCI-P write requests (power of 2, 2..64).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; it is asynchronous and active-high.
REQ-004 SHALL have port buffer_addr, input, 64, host byte address of the result buffer from the CSRs; 0 means not programmed.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a write-back job.
REQ-006 SHALL have port num_lines, input, 16, the number of 64-byte lines in the job.
REQ-007 SHALL have port wr_data_valid, input, 1, meaning result line data is valid.
REQ-008 SHALL have port wr_data, input, 512, the result line.
REQ-009 SHALL have port wr_data_ready, output, 1, meaning the block accepts wr_data this cycle.
REQ-010 SHALL have port c1_almost_full, input, 1, the CCI-P c1TxAlmFull back-pressure signal.
REQ-011 SHALL have port c1_tx_valid, output, 1, the CCI-P channel-1 write request valid.
REQ-012 SHALL have port c1_tx_addr, output, 42, the cache-line address of the write.
REQ-013 SHALL have port c1_tx_data, output, 512, the write payload.
REQ-014 SHALL have port c1_tx_mdata, output, 16, the request tag, equal to the line index.
REQ-015 SHALL have port c1_rx_valid, input, 1, a channel-1 write response (one line acknowledged).
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1, a one-cycle job-complete pulse.
REQ-018 SHALL have port lines_written, output, 16, the count of acknowledged lines in the current or last job.

Function
REQ-019 SHALL implement states IDLE, WRITE, DRAIN and DONE.
REQ-020 SHALL, in IDLE, on start=1 with buffer_addr!=0, latch base=buffer_addr[47:6] and total=num_lines, clear issued, outstanding and lines_written, and go to WRITE (or to DONE if num_lines==0).
REQ-021 SHALL ignore start in IDLE when buffer_addr==0, and ignore start in every non-IDLE state.
REQ-022 SHALL drive wr_data_ready = (state==WRITE) && !c1_almost_full && (outstanding<MAX_OUTSTANDING) && (issued<total), combinationally.
REQ-023 SHALL, on a wr_data_valid && wr_data_ready handshake, assert c1_tx_valid on the next cycle only, with c1_tx_addr=(base+issued) mod 2^42, c1_tx_data=wr_data and c1_tx_mdata=issued, then increment issued and outstanding.
REQ-024 SHALL hold c1_tx_valid low on every cycle with no handshake in the previous cycle; one request is issued per accepted line, at most one per cycle.
REQ-025 SHALL, on each c1_rx_valid, decrement outstanding and increment lines_written.
REQ-026 SHALL leave outstanding unchanged when a handshake and a response occur in the same cycle.
REQ-027 SHALL ignore c1_rx_valid when outstanding==0 (no underflow, lines_written unchanged).
REQ-028 SHALL go WRITE->DRAIN in the cycle after issued reaches total.
REQ-029 SHALL go DRAIN->DONE when outstanding==0 and c1_tx_valid==0.
REQ-030 SHALL, in DONE, assert done for exactly one cycle and return to IDLE.
REQ-031 SHALL hold lines_written after DONE until the next accepted start.
REQ-032 SHALL let c1_almost_full only block new acceptances; a request already registered is still emitted on the following cycle.

Reset
REQ-033 SHALL, while rst=1, immediately force state=IDLE, clear issued, outstanding, base, total and lines_written, and drive wr_data_ready, c1_tx_valid, c1_tx_addr, c1_tx_data, c1_tx_mdata, busy and done to 0.
REQ-034 SHALL, when reset occurs mid-job, abandon the job without emitting any further requests; responses arriving after release are ignored per REQ-027.

Verification
REQ-035 SHALL verify: buffer_addr=0x1000, num_lines=4, data always valid, each response 5 cycles after its request -> addresses 0x40..0x43, mdata 0..3, one done pulse, lines_written=4.
REQ-036 SHALL verify: MAX_OUTSTANDING=16, num_lines=20, responses withheld -> exactly 16 requests, wr_data_ready=0; releasing one response -> exactly one more request.
REQ-037 SHALL verify: c1_almost_full=1 for 10 cycles mid-job -> no new handshakes during that window; the job then completes with all lines written in order.
REQ-038 SHALL verify: start with num_lines=0 -> done pulse 2 cycles after start, no c1_tx_valid; start with buffer_addr=0 -> busy stays 0.
REQ-039 SHALL verify: buffer_addr=0x3FF_FFFF_FFFF_FFC0, num_lines=2 -> c1_tx_addr values 0x3FF_FFFF_FFFF then 0x000_0000_0000 (wrap).
REQ-040 SHALL verify: rst pulsed after 3 of 8 lines are issued -> all outputs 0 immediately, late responses ignored, and a new job then runs correctly.
